// File: rtl/arm_lsu_pkg.sv
// Shared types and constants for the ARM load/store unit.
package arm_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] DMEM_BASE = 32'h1000_0000;
    localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/arm_lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Latency: combinational.
// Backpressure: none.
module arm_lsu_align
    import arm_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] mem_word,
    input  logic [31:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [31:0] rot;
    logic [31:0] mask;
    logic [31:0] rep;
    logic [4:0]  sh;

    always_comb begin
        // Rotating right by the lane puts the addressed byte/half at bit 0,
        // which also gives the ARM unaligned-LDR result for word loads.
        case (lane)
            2'd1:    rot = {mem_word[7:0],  mem_word[31:8]};
            2'd2:    rot = {mem_word[15:0], mem_word[31:16]};
            2'd3:    rot = {mem_word[23:0], mem_word[31:24]};
            default: rot = mem_word;
        endcase

        ld_data = '0;
        st_word = st_data;
        mask    = '0;
        rep     = '0;
        sh      = '0;
        case (size)
            SZ_BYTE: begin
                ld_data = {{24{sign_ext & rot[7]}}, rot[7:0]};
                sh      = {lane, 3'b000};
                mask    = 32'h0000_00FF << sh;
                rep     = {4{st_data[7:0]}};
                st_word = (mem_word & ~mask) | (rep & mask);
            end
            SZ_HALF: begin
                ld_data = {{16{sign_ext & rot[15]}}, rot[15:0]};
                sh      = {lane[1], 4'b0000};
                mask    = 32'h0000_FFFF << sh;
                rep     = {2{st_data[15:0]}};
                st_word = (mem_word & ~mask) | (rep & mask);
            end
            SZ_WORD: ld_data = rot;
            default: ;
        endcase
    end

endmodule

// File: rtl/arm_load_store_unit.sv
// Load/store unit driving the arm_memory data port with word-wide cycles.
// Latency: fault 1, load/word store 2, sub-word store (read-modify-write) 3 cycles.
// Backpressure: req_ready only in IDLE; responses cannot be stalled.
module arm_load_store_unit
    import arm_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_excpt
);

    lsu_state_t        state_q, state_d;
    logic              accept;
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] data_q;
    logic              fault_q;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

    assign req_ready = (state_q == ST_IDLE);

    arm_lsu_align u_align (
        .size     (size_q),
        .sign_ext (signed_q),
        .lane     (lane_q),
        .mem_word (mem_rdata),
        .st_data  (wdata_q),
        .ld_data  (ld_data),
        .st_word  (st_word)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (req_size == 2'd3 || (req_size == SZ_HALF && req_addr[0]))
                        state_d = ST_RESP;
                    else if (!req_we)
                        state_d = ST_RD;
                    else if (req_size == SZ_WORD)
                        state_d = ST_WR;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_RD, ST_WR, ST_RMW_WR: state_d = ST_RESP;
            ST_RMW_RD: state_d = mem_excpt ? ST_RESP : ST_RMW_WR;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q       <= 1'b0;
            size_q     <= '0;
            signed_q   <= 1'b0;
            lane_q     <= '0;
            wdata_q    <= '0;
            data_q     <= '0;
            fault_q    <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= '0;
            mem_we     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        data_q    <= '0;
                        fault_q   <= (state_d == ST_RESP);
                        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata <= req_wdata;
                        mem_we    <= (state_d == ST_WR);
                    end
                end
                ST_RD: begin
                    data_q  <= ld_data;
                    fault_q <= mem_excpt;
                end
                ST_WR: fault_q <= mem_excpt;
                ST_RMW_RD: begin
                    // An unmapped read aborts the store before any write is issued.
                    if (mem_excpt) begin
                        fault_q <= 1'b1;
                    end else begin
                        mem_wdata <= st_word;
                        mem_we    <= 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b1;
                    resp_fault <= fault_q;
                    resp_rdata <= (fault_q || we_q) ? '0 : data_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arm_load_store_unit.sv
// Bench for arm_load_store_unit with a behavioural arm_memory data port behind it.
module tb_arm_load_store_unit;
    import arm_lsu_pkg::*;

    logic        clk, rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_excpt;

    arm_load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_excpt(mem_excpt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 4 KiB at DMEM_BASE and at IMEM_BASE, everything else unmapped.
    logic [31:0] dmem [0:1023];
    logic [31:0] imem [0:1023];
    logic in_dmem, in_imem;
    always_comb begin
        in_dmem   = (mem_addr[31:12] == DMEM_BASE[31:12]);
        in_imem   = (mem_addr[31:12] == IMEM_BASE[31:12]);
        mem_excpt = !(in_dmem || in_imem);
        mem_rdata = in_dmem ? dmem[mem_addr[11:2]] : (in_imem ? imem[mem_addr[11:2]] : 32'h0);
    end
    always @(posedge clk) begin
        if (mem_we && in_dmem) dmem[mem_addr[11:2]] <= mem_wdata;
        if (mem_we && in_imem) imem[mem_addr[11:2]] <= mem_wdata;
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cnt = 0;
    int we_cnt   = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
        int          idx;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin
        if (resp_valid) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata %h fault %0d with nothing pending", resp_rdata, resp_fault);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("v%0d_rdata", e.idx), resp_rdata, e.rdata);
                check($sformatf("v%0d_fault", e.idx), 32'(resp_fault), 32'(e.fault));
                check($sformatf("v%0d_latency", e.idx), 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_fault;
        int          exp_lat;
        int          exp_we;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] rd, logic flt, int lat, int wen);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = rd; v.exp_fault = flt; v.exp_lat = lat; v.exp_we = wen;
        return v;
    endfunction

    task automatic run_vec(input int i);
        int rc0, wc0, n;
        @(negedge clk);
        check($sformatf("v%0d_ready_idle", i), 32'(req_ready), 32'd1);
        rc0 = resp_cnt;
        wc0 = we_cnt;
        req_valid  = 1'b1;
        req_we     = vecs[i].we;
        req_size   = vecs[i].size;
        req_signed = vecs[i].sgn;
        req_addr   = vecs[i].addr;
        req_wdata  = vecs[i].wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'hA5A5_A5A5;
        sb.push_back('{vecs[i].exp_rdata, vecs[i].exp_fault, vecs[i].exp_lat, cyc, i});
        check($sformatf("v%0d_ready_busy", i), 32'(req_ready), 32'd0);
        n = 0;
        while (resp_cnt == rc0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (resp_cnt == rc0) begin
            total++;
            bad++;
            $display("FAIL v%0d_timeout: got no response want one within 20 cycles", i);
            void'(sb.pop_front());
        end
        check($sformatf("v%0d_we_cycles", i), 32'(we_cnt - wc0), 32'(vecs[i].exp_we));
    endtask

    task automatic reset_mid(input string name, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic exp_we_now);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = size; req_signed = 1'b0;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        check({name, "_we_before"}, 32'(mem_we), 32'(exp_we_now));
        rst = 1'b1;
        #1;
        check({name, "_we_async"}, 32'(mem_we), 32'd0);
        check({name, "_ready_async"}, 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check({name, "_ready_after"}, 32'(req_ready), 32'd1);
        check({name, "_no_resp"}, 32'(resp_valid), 32'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) begin
            dmem[k] = 32'h0;
            imem[k] = 32'h0;
        end
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;

        //                 we    size     sgn   addr          wdata          rdata          flt  lat we
        vecs[0]  = mk(1'b1, SZ_WORD, 1'b0, 32'h1000_0000, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 1);
        vecs[1]  = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 2, 0);
        vecs[2]  = mk(1'b1, SZ_BYTE, 1'b0, 32'h1000_0002, 32'h1234_5655, 32'h0,         1'b0, 3, 1);
        vecs[3]  = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_0000, 32'h0,         32'hDE55_BEEF, 1'b0, 2, 0);
        vecs[4]  = mk(1'b0, SZ_HALF, 1'b0, 32'h1000_0002, 32'h0,         32'h0000_DE55, 1'b0, 2, 0);
        vecs[5]  = mk(1'b0, SZ_HALF, 1'b1, 32'h1000_0002, 32'h0,         32'hFFFF_DE55, 1'b0, 2, 0);
        vecs[6]  = mk(1'b0, SZ_BYTE, 1'b1, 32'h1000_0000, 32'h0,         32'hFFFF_FFEF, 1'b0, 2, 0);
        vecs[7]  = mk(1'b0, SZ_BYTE, 1'b0, 32'h1000_0001, 32'h0,         32'h0000_00BE, 1'b0, 2, 0);
        vecs[8]  = mk(1'b1, SZ_WORD, 1'b0, 32'h1000_0004, 32'h8011_2233, 32'h0,         1'b0, 2, 1);
        vecs[9]  = mk(1'b0, SZ_BYTE, 1'b1, 32'h1000_0007, 32'h0,         32'hFFFF_FF80, 1'b0, 2, 0);
        vecs[10] = mk(1'b1, SZ_WORD, 1'b0, 32'h1000_0008, 32'h4433_2211, 32'h0,         1'b0, 2, 1);
        vecs[11] = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_0009, 32'h0,         32'h1144_3322, 1'b0, 2, 0);
        vecs[12] = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_000B, 32'h0,         32'h3322_1144, 1'b0, 2, 0);
        vecs[13] = mk(1'b1, SZ_HALF, 1'b0, 32'h1000_000A, 32'h1234_ABCD, 32'h0,         1'b0, 3, 1);
        vecs[14] = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_0008, 32'h0,         32'hABCD_2211, 1'b0, 2, 0);
        vecs[15] = mk(1'b0, SZ_HALF, 1'b0, 32'h1000_0001, 32'h0,         32'h0,         1'b1, 1, 0);
        vecs[16] = mk(1'b1, SZ_BYTE, 1'b0, 32'h0100_0000, 32'h0000_0077, 32'h0,         1'b1, 2, 0);
        vecs[17] = mk(1'b0, 2'd3,    1'b0, 32'h1000_0000, 32'h0,         32'h0,         1'b1, 1, 0);
        vecs[18] = mk(1'b1, SZ_WORD, 1'b0, 32'h0100_0000, 32'h1111_2222, 32'h0,         1'b1, 2, 1);
        vecs[19] = mk(1'b0, SZ_WORD, 1'b0, 32'h0200_0000, 32'h0,         32'h0,         1'b1, 2, 0);
        vecs[20] = mk(1'b1, SZ_WORD, 1'b0, 32'h1000_0006, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 1);
        vecs[21] = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_0004, 32'h0,         32'hCAFE_F00D, 1'b0, 2, 0);
        vecs[22] = mk(1'b0, SZ_HALF, 1'b1, 32'h1000_0006, 32'h0,         32'hFFFF_CAFE, 1'b0, 2, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_fault", 32'(resp_fault), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) run_vec(i);

        check("dmem0_after_strb", dmem[0], 32'hDE55_BEEF);
        check("dmem2_after_strh", dmem[2], 32'hABCD_2211);

        // Reset in RMW_RD of a byte store, then in WR of a word store: no write may land.
        reset_mid("rst_rmw", SZ_BYTE, 32'h1000_0000, 32'h0000_0099, 1'b0);
        check("rst_rmw_word", dmem[0], 32'hDE55_BEEF);
        reset_mid("rst_wr", SZ_WORD, 32'h1000_0000, 32'h1357_9BDF, 1'b1);
        check("rst_wr_word", dmem[0], 32'hDE55_BEEF);
        check("rst_sb_empty", 32'(sb.size()), 32'd0);

        vecs[0] = mk(1'b0, SZ_WORD, 1'b0, 32'h1000_0000, 32'h0, 32'hDE55_BEEF, 1'b0, 2, 0);
        run_vec(0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
